display_controller: RTL and testbench
=====================================

// Module: display_controller
// PURPOSE
//   Owns the 4-digit seven-segment frame buffer and feeds the 4-digit multiplexed display driver.
//   - Arbitrates digit writes from two requesters: A is game logic, B is status/debug.
//   - Generates the slow display_clock that steps the driver's digit scan.
//   - Applies per-digit blinking.
//   Sits between the game FSM and the display driver.
// PARAMETERS
//   REFRESH_DIV  50000  clock cycles per display_clock half-period (>=2)
//   BLINK_DIV    250    display_clock rising edges per blink-phase toggle (>=1)
//   STARVE_MAX   3      consecutive A grants allowed while B waits (>=1)
// PORTS
//   clock          in   1  system clock
//   reset_n        in   1  asynchronous reset, active-low
//   req_a          in   1  requester A write request (held until gnt_a)
//   req_a_addr     in   2  A digit index: 0=digitA .. 3=digitD
//   req_a_data     in   8  A segment pattern (active-low segments)
//   gnt_a          out  1  one-cycle grant to A
//   req_b          in   1  requester B write request
//   req_b_addr     in   2  B digit index
//   req_b_data     in   8  B segment pattern
//   gnt_b          out  1  one-cycle grant to B
//   blink_mask     in   4  bit i=1: digit i blinks
//   lamp_test      in   1  present only with DISPLAY_LAMP_TEST_EN
//   display_clock  out  1  registered square wave to driver scan clock
//   digitA..digitD out  8  each: segment pattern to driver
// BEHAVIOUR
// - Reset (async, reset_n=0):
//   - buffer all 8'hFF (blank).
//   - gnt_a=gnt_b=0; FSM=IDLE; display_clock=0; blink phase=0; starve count=0.
//   - All prescaler counters=0.
// - Arbiter FSM, states IDLE -> GRANT -> COOL -> IDLE:
//   - IDLE: if any req is sampled high at edge k:
//     - choose a winner and capture its addr/data; go to GRANT.
//     - gnt_x=1 during cycle k+1, exactly one cycle.
//   - GRANT: buffer[addr]<=data at end of k+1; visible on digitX from cycle k+2. Then go to COOL.
//   - COOL: one cycle with no grant, so the winner can drop req. Then IDLE.
//   - Max throughput: one write per 3 cycles.
//   - Write uses captured values; if req drops during GRANT, the write still completes.
// - Priority:
//   - A beats B, except when starve count==STARVE_MAX and req_b=1; then B wins.
//   - Starve count: +1 on each A grant while req_b=1 (saturating).
//   - Starve count clears on a B grant, or when req_b=0 in IDLE.
//   - Only one requester high: it wins immediately.
// - Refresh: counter 0..REFRESH_DIV-1; display_clock toggles at terminal count.
//   - Period = 2*REFRESH_DIV clocks; first rising edge at cycle REFRESH_DIV after reset.
// - Blink: a second counter counts display_clock rising edges 0..BLINK_DIV-1.
//   - Phase toggles at terminal count.
//   - digitX = (phase && blink_mask[X]) ? 8'hFF : buffer[X], combinational on phase/mask/buffer.
// - Counters wrap to 0 at terminal count. Reset mid-grant aborts the write; buffer returns to blank.
// CONFIGURATION
// - `DISPLAY_LAMP_TEST_EN defined:
//   - lamp_test port exists.
//   - While 1, all digits = 8'h00 (all segments on), overriding blink; buffer and arbitration unaffected.
// - Undefined: no lamp_test port; outputs never forced.
// STRUCTURE
// - Shared include display_defs.vh:
//   - SEG_BLANK=8'hFF, SEG_ALL_ON=8'h00.
//   - FSM state encodings IDLE/GRANT/COOL.
//   - DIGIT_A..DIGIT_D index constants.
// - Sub-module display_prescaler (param DIV; ports clock, reset_n, enable, tick):
//   - tick is a one-cycle pulse at the terminal count.
//   - Instantiated for refresh (enable=1) and for blink (enable=display_clock rising pulse).
// TESTING  (REFRESH_DIV=4, BLINK_DIV=2, STARVE_MAX=3 unless noted)
// - Reset: reset_n=0 with random inputs -> digitA..D=8'hFF, gnt_a=gnt_b=0, display_clock=0.
// - Single write: req_a=1, addr=2, data=8'hC0 at edge k -> gnt_a high only in cycle k+1; digitC=8'hC0 from k+2.
// - Contention: req_a and req_b held, both re-asserted after each grant -> grant order A,A,A,B,A,A,A,B.
// - Clock/blink:
//   - display_clock period = 8 cycles.
//   - blink_mask=4'b0001, digitA=8'hC0 -> digitA shows 8'hFF after 2 display_clock rises, 8'hC0 after 2 more.
// - Reset mid-operation: reset_n=0 during the GRANT cycle -> gnt_a drops at once; target digit stays 8'hFF after release.
// - Lamp test (macro on): lamp_test=1 -> all digits 8'h00 despite blink; release -> buffer contents shown.

Source files
------------

// File: rtl/display_controller_pkg.sv
// display_controller_pkg: shared constants and arbiter state type for the display controller.
//   SEG_BLANK / SEG_ALL_ON : active-low segment patterns (all off / all on)
//   DIGIT_A..DIGIT_D       : frame-buffer indices
//   state_e                : arbiter states IDLE -> GRANT -> COOL
package display_controller_pkg;
  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam logic [7:0] SEG_ALL_ON = 8'h00;
  localparam int DIGIT_A = 0;
  localparam int DIGIT_B = 1;
  localparam int DIGIT_C = 2;
  localparam int DIGIT_D = 3;
  typedef enum logic [1:0] {IDLE, GRANT, COOL} state_e;
endpackage

// File: rtl/display_prescaler.sv
// display_prescaler: enabled modulo-DIV counter emitting a one-cycle tick at terminal count.
//   clock, reset_n : clock and async active-low reset
//   enable         : advance the count this cycle
//   tick           : high while enabled at count DIV-1 (counter wraps to 0)
module display_prescaler #(
  parameter int DIV = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick  = enable && cnt_q == W'(DIV - 1);
    cnt_d = tick ? '0 : cnt_q + W'(enable);
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/display_controller.sv
// display_controller: 4-digit frame buffer with two-requester write arbiter, scan clock and blink.
//   clock, reset_n            : clock and async active-low reset
//   req_a/_addr/_data, gnt_a  : requester A (game logic), priority except when B is starved
//   req_b/_addr/_data, gnt_b  : requester B (status/debug)
//   blink_mask                : per-digit blink enable
//   lamp_test                 : forces all segments on (only with DISPLAY_LAMP_TEST_EN)
//   display_clock             : registered scan clock, period 2*REFRESH_DIV
//   digitA..digitD            : segment patterns to the driver
module display_controller
  import display_controller_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 250,
  parameter int STARVE_MAX  = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req_a,
  input  logic [1:0] req_a_addr,
  input  logic [7:0] req_a_data,
  output logic       gnt_a,
  input  logic       req_b,
  input  logic [1:0] req_b_addr,
  input  logic [7:0] req_b_data,
  output logic       gnt_b,
  input  logic [3:0] blink_mask,
`ifdef DISPLAY_LAMP_TEST_EN
  input  logic       lamp_test,
`endif
  output logic       display_clock,
  output logic [7:0] digitA,
  output logic [7:0] digitB,
  output logic [7:0] digitC,
  output logic [7:0] digitD
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  state_e state_q, state_d;
  logic win_b_q, win_b_d, b_wins;
  logic [1:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [7:0] buf_q [4];
  logic [7:0] seg [4];
  logic dclk_q, phase_q, ref_tick, blink_tick;

  display_prescaler #(.DIV(REFRESH_DIV)) u_refresh (
    .clock(clock), .reset_n(reset_n), .enable(1'b1), .tick(ref_tick)
  );
  // Counts scan-clock rising edges: the refresh tick that lifts display_clock from 0.
  display_prescaler #(.DIV(BLINK_DIV)) u_blink (
    .clock(clock), .reset_n(reset_n), .enable(ref_tick && !dclk_q), .tick(blink_tick)
  );

  always_comb begin
    state_d  = state_q;
    win_b_d  = win_b_q;
    addr_d   = addr_q;
    data_d   = data_q;
    starve_d = starve_q;
    b_wins   = req_b && (!req_a || starve_q == SW'(STARVE_MAX));
    if (state_q == IDLE) begin
      if (req_a || req_b) begin
        state_d = GRANT;
        win_b_d = b_wins;
        addr_d  = b_wins ? req_b_addr : req_a_addr;
        data_d  = b_wins ? req_b_data : req_a_data;
      end
      // Reaching here with req_b high and B losing implies an A grant while B waits.
      starve_d = (!req_b || b_wins) ? '0 :
                 starve_q == SW'(STARVE_MAX) ? starve_q : starve_q + 1'b1;
    end else begin
      state_d = state_q == GRANT ? COOL : IDLE;
    end
    gnt_a = state_q == GRANT && !win_b_q;
    gnt_b = state_q == GRANT && win_b_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      win_b_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= SEG_BLANK;
      starve_q <= '0;
      dclk_q   <= 1'b0;
      phase_q  <= 1'b0;
      for (int i = 0; i < 4; i++) buf_q[i] <= SEG_BLANK;
    end else begin
      state_q  <= state_d;
      win_b_q  <= win_b_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      starve_q <= starve_d;
      dclk_q   <= dclk_q ^ ref_tick;
      phase_q  <= phase_q ^ blink_tick;
      if (state_q == GRANT) buf_q[addr_q] <= data_q;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      seg[i] = (phase_q && blink_mask[i]) ? SEG_BLANK : buf_q[i];
`ifdef DISPLAY_LAMP_TEST_EN
      if (lamp_test) seg[i] = SEG_ALL_ON;
`endif
    end
  end

  assign display_clock = dclk_q;
  assign digitA = seg[DIGIT_A];
  assign digitB = seg[DIGIT_B];
  assign digitC = seg[DIGIT_C];
  assign digitD = seg[DIGIT_D];
endmodule

// File: tb/tb_display_controller.sv
// tb_display_controller: randomized self-checking bench against a cycle-count reference model.
module tb_display_controller;
  localparam int RD = 4;
  localparam int BD = 2;
  localparam int SM = 3;

  logic clock = 1'b0;
  logic reset_n;
  logic req_a, req_b, gnt_a, gnt_b, display_clock, lamp_test;
  logic [1:0] req_a_addr, req_b_addr;
  logic [7:0] req_a_data, req_b_data, digitA, digitB, digitC, digitD;
  logic [3:0] blink_mask;

  int total = 0;
  int passed = 0;

  int n, next_free, starve;
  logic [7:0] mbuf [4];
  bit ga, gb;
  logic [1:0] waddr;
  logic [7:0] wdata;

  always #5 clock = ~clock;

  display_controller #(.REFRESH_DIV(RD), .BLINK_DIV(BD), .STARVE_MAX(SM)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_a(req_a), .req_a_addr(req_a_addr), .req_a_data(req_a_data), .gnt_a(gnt_a),
    .req_b(req_b), .req_b_addr(req_b_addr), .req_b_data(req_b_data), .gnt_b(gnt_b),
    .blink_mask(blink_mask),
`ifdef DISPLAY_LAMP_TEST_EN
    .lamp_test(lamp_test),
`endif
    .display_clock(display_clock),
    .digitA(digitA), .digitB(digitB), .digitC(digitC), .digitD(digitD)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    else passed++;
  endtask

  task automatic model_reset();
    n = 0;
    next_free = 1;
    starve = 0;
    ga = 0;
    gb = 0;
    for (int i = 0; i < 4; i++) mbuf[i] = 8'hFF;
  endtask

  // Expected outputs after n clock edges since reset release, from period arithmetic.
  task automatic check_all();
    int m, rises, phase;
    logic [7:0] dig [4];
    logic [7:0] e;
    m = n / RD;
    rises = (m + 1) / 2;
    phase = (rises / BD) % 2;
    dig = '{digitA, digitB, digitC, digitD};
    chk("gnt_a", 32'(gnt_a), 32'(ga));
    chk("gnt_b", 32'(gnt_b), 32'(gb));
    chk("display_clock", 32'(display_clock), 32'(m % 2));
    for (int i = 0; i < 4; i++) begin
      e = (phase == 1 && blink_mask[i]) ? 8'hFF : mbuf[i];
`ifdef DISPLAY_LAMP_TEST_EN
      if (lamp_test) e = 8'h00;
`endif
      chk($sformatf("digit%0d", i), 32'(dig[i]), 32'(e));
    end
  endtask

  // One clock: the model samples the requests at the edge, then outputs are checked mid-cycle.
  task automatic step();
    bit bw;
    @(posedge clock);
    n++;
    if (ga || gb) mbuf[waddr] = wdata;
    ga = 0;
    gb = 0;
    if (n >= next_free) begin
      bw = req_b && (!req_a || starve == SM);
      if (req_a || req_b) begin
        ga = !bw;
        gb = bw;
        waddr = bw ? req_b_addr : req_a_addr;
        wdata = bw ? req_b_data : req_a_data;
        next_free = n + 3;
      end
      starve = (!req_b || bw) ? 0 : (starve < SM ? starve + 1 : starve);
    end
    @(negedge clock);
    check_all();
  endtask

  initial begin
    logic [7:0] order;
    int cnt, r1, r2;
    logic prev;
    req_a = 0; req_b = 0; req_a_addr = 0; req_b_addr = 0;
    req_a_data = 0; req_b_data = 0; blink_mask = 0; lamp_test = 0;
    reset_n = 1;
    #1 reset_n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      req_a = 1'($urandom); req_b = 1'($urandom);
      req_a_addr = 2'($urandom); req_b_addr = 2'($urandom);
      req_a_data = 8'($urandom); req_b_data = 8'($urandom);
      blink_mask = 4'($urandom);
      #1;
      chk("rst_digits", {digitA, digitB, digitC, digitD}, 32'hFFFF_FFFF);
      chk("rst_gnt", 32'({gnt_a, gnt_b}), 32'd0);
      chk("rst_dclk", 32'(display_clock), 32'd0);
    end
    @(negedge clock);
    req_a = 0; req_b = 0; blink_mask = 0;
    reset_n = 1;
    model_reset();

    req_a = 1; req_a_addr = 2; req_a_data = 8'hC0;
    step();
    chk("sw_gnt_a", 32'(gnt_a), 32'd1);
    req_a = 0;
    step();
    chk("sw_gnt_a_once", 32'(gnt_a), 32'd0);
    chk("sw_digitC", 32'(digitC), 32'hC0);
    step();

    req_a = 1; req_b = 1;
    req_a_addr = 0; req_b_addr = 3;
    req_a_data = 8'($urandom); req_b_data = 8'($urandom);
    order = 0;
    cnt = 0;
    for (int i = 0; i < 40 && cnt < 8; i++) begin
      step();
      if (gnt_a || gnt_b) begin
        order[cnt] = gnt_b;
        cnt++;
      end
    end
    chk("cont_order", 32'(order), 32'h88);
    req_a = 0; req_b = 0;

    r1 = -1; r2 = -1;
    prev = display_clock;
    for (int i = 0; i < 600; i++) begin
      if (!req_a || ga) begin
        req_a = 1'($urandom); req_a_addr = 2'($urandom); req_a_data = 8'($urandom);
      end
      if (!req_b || gb) begin
        req_b = 1'($urandom); req_b_addr = 2'($urandom); req_b_data = 8'($urandom);
      end
      if ($urandom_range(0, 15) == 0) blink_mask = 4'($urandom);
      step();
      if (display_clock && !prev) begin
        if (r1 < 0) r1 = n;
        else if (r2 < 0) r2 = n;
      end
      prev = display_clock;
    end
    chk("dclk_period", 32'(r2 - r1), 32'(2 * RD));

`ifdef DISPLAY_LAMP_TEST_EN
    req_a = 0; req_b = 0;
    blink_mask = 4'hF;
    lamp_test = 1;
    repeat (20) step();
    chk("lamp_digits", {digitA, digitB, digitC, digitD}, 32'h0);
    lamp_test = 0;
    blink_mask = 0;
    step();
    chk("lamp_release", 32'(digitC), 32'(mbuf[2]));
`endif

    req_a = 0; req_b = 0; blink_mask = 0;
    repeat (3) step();
    req_a = 1; req_a_addr = 1; req_a_data = 8'h3C;
    step();
    chk("mg_gnt_a", 32'(gnt_a), 32'd1);
    reset_n = 0;
    #1;
    chk("mg_gnt_drop", 32'(gnt_a), 32'd0);
    req_a = 0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1;
    model_reset();
    step();
    chk("mg_digitB", 32'(digitB), 32'hFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
